sniffer_pkt_ctrl: RTL and testbench

Parametrised packet-sequencing controller for the Ethernet sniffer datapath. It loads comparator configuration, accepts frames from the MAC into the input FIFO, drains them through NUM_CH parallel comparators, and waits a configurable pipeline latency. It then evaluates a per-channel enable mask and commits matching frames to capture memory at an internally maintained address. It also counts received, matched and dropped frames and bounds frame length.

---
 rtl/sniffer_pkt_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sniffer_pkt_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sniffer_pkt_ctrl.sv
// Frame sequencing controller for the Ethernet sniffer: loads comparator config,
// steers MAC frames through the input FIFO and comparators, and commits hits to capture memory.
module sniffer_pkt_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CMP_LAT   = 4,
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 380,
    parameter int WRAP      = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              update_done,
    input  logic              ready,
    input  logic              eop,
    input  logic              error,
    input  logic              rdempty,
    input  logic [NUM_CH-1:0] match,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              fifo_wrreq,
    output logic              fifo_rdreq,
    output logic              cfg_load,
    output logic              clear,
    output logic              inc_addr,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [NUM_CH-1:0] match_vec,
    output logic              mem_full,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int WC_W  = $clog2(MAX_WORDS + 1);
    localparam int LAT_W = 4;

    typedef enum logic [3:0] {
        RESET, LOAD_CFG, IDLE, RECEIVE, DRAIN, SETTLE, DECIDE, STORE, ERROR, FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   word_q, word_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              pkt_inc, drop_inc, commit;
    logic              hit;
    logic [ADDR_W-1:0] addr_inc;

    logic              fifo_wrreq_q, fifo_rdreq_q, cfg_load_q, clear_q, inc_addr_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [NUM_CH-1:0] match_vec_q;
    logic              mem_full_q;
    logic [CNT_W-1:0]  pkt_cnt_q, match_cnt_q, drop_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign hit      = |(match & ch_en);
    assign addr_inc = cap_addr_q + ADDR_W'(1);

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        lat_d    = lat_q;
        pkt_inc  = 1'b0;
        drop_inc = 1'b0;
        commit   = 1'b0;
        case (state_q)
            RESET:    state_d = LOAD_CFG;
            LOAD_CFG: if (update_done) state_d = IDLE;
            IDLE: begin
                word_d = '0;
                if (ready) state_d = RECEIVE;
            end
            RECEIVE: begin
                word_d = word_q + WC_W'(1);
                // A frame error wins over eop; eop alongside it skips ERROR entirely.
                if (error) begin
                    state_d = eop ? FLUSH : ERROR;
                end else if (eop) begin
                    state_d = DRAIN;
                    pkt_inc = 1'b1;
                end else if (word_q == WC_W'(MAX_WORDS - 1)) begin
                    state_d  = ERROR;
                    drop_inc = 1'b1;
                end
            end
            DRAIN: begin
                if (rdempty) begin
                    state_d = SETTLE;
                    lat_d   = LAT_W'(CMP_LAT - 1);
                end
            end
            SETTLE: begin
                if (lat_q == '0) state_d = DECIDE;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            DECIDE: begin
                state_d = IDLE;
                if (hit) begin
                    if (mem_full_q) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = STORE;
                        commit  = 1'b1;
                    end
                end
            end
            STORE:   state_d = IDLE;
            ERROR:   if (eop) state_d = FLUSH;
            FLUSH:   if (rdempty) state_d = IDLE;
            default: state_d = RESET;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= RESET;
            word_q       <= '0;
            lat_q        <= '0;
            fifo_wrreq_q <= 1'b0;
            fifo_rdreq_q <= 1'b0;
            cfg_load_q   <= 1'b0;
            clear_q      <= 1'b0;
            inc_addr_q   <= 1'b0;
            cap_addr_q   <= '0;
            match_vec_q  <= '0;
            mem_full_q   <= 1'b0;
            pkt_cnt_q    <= '0;
            match_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            lat_q        <= lat_d;
            fifo_wrreq_q <= (state_d == RECEIVE);
            fifo_rdreq_q <= (state_d == DRAIN) || ((state_d == FLUSH) && !rdempty);
            cfg_load_q   <= (state_d == LOAD_CFG);
            clear_q      <= (state_d == IDLE);
            inc_addr_q   <= (state_d == STORE);
            if (pkt_inc)  pkt_cnt_q  <= sat_inc(pkt_cnt_q);
            if (drop_inc) drop_cnt_q <= sat_inc(drop_cnt_q);
            if (commit) begin
                match_vec_q <= match & ch_en;
                match_cnt_q <= sat_inc(match_cnt_q);
                cap_addr_q  <= addr_inc;
                // Without wrap the last slot is the final one; further hits are dropped.
                if ((WRAP == 0) && (addr_inc == '1)) mem_full_q <= 1'b1;
            end
        end
    end

    assign fifo_wrreq = fifo_wrreq_q;
    assign fifo_rdreq = fifo_rdreq_q;
    assign cfg_load   = cfg_load_q;
    assign clear      = clear_q;
    assign inc_addr   = inc_addr_q;
    assign cap_addr   = cap_addr_q;
    assign match_vec  = match_vec_q;
    assign mem_full   = mem_full_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign match_cnt  = match_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_sniffer_pkt_ctrl.sv
// Bench for sniffer_pkt_ctrl: a saturating (WRAP=0) and a wrapping (WRAP=1) instance share stimulus.
module tb_sniffer_pkt_ctrl;
    localparam int NCH = 4, LAT = 3, AW = 2, MAXW = 16, CW = 8;

    logic clk = 1'b0, n_rst = 1'b0, update_done = 1'b0, ready = 1'b0, eop = 1'b0, error = 1'b0;
    logic [NCH-1:0] match = '0, ch_en = '0;
    logic rdempty;
    int   fcnt = 0;

    logic wr0, rd0, cfg0, clr0, inc0, full0, wr1, rd1, cfg1, clr1, inc1, full1;
    logic [AW-1:0]  addr0, addr1;
    logic [NCH-1:0] vec0, vec1;
    logic [CW-1:0]  pkt0, mcnt0, drop0, pkt1, mcnt1, drop1;

    sniffer_pkt_ctrl #(.NUM_CH(NCH), .CMP_LAT(LAT), .ADDR_W(AW), .MAX_WORDS(MAXW), .WRAP(0), .CNT_W(CW)) u0 (
        .clk(clk), .n_rst(n_rst), .update_done(update_done), .ready(ready), .eop(eop), .error(error),
        .rdempty(rdempty), .match(match), .ch_en(ch_en), .fifo_wrreq(wr0), .fifo_rdreq(rd0),
        .cfg_load(cfg0), .clear(clr0), .inc_addr(inc0), .cap_addr(addr0), .match_vec(vec0),
        .mem_full(full0), .pkt_cnt(pkt0), .match_cnt(mcnt0), .drop_cnt(drop0));

    sniffer_pkt_ctrl #(.NUM_CH(NCH), .CMP_LAT(LAT), .ADDR_W(AW), .MAX_WORDS(MAXW), .WRAP(1), .CNT_W(CW)) u1 (
        .clk(clk), .n_rst(n_rst), .update_done(update_done), .ready(ready), .eop(eop), .error(error),
        .rdempty(rdempty), .match(match), .ch_en(ch_en), .fifo_wrreq(wr1), .fifo_rdreq(rd1),
        .cfg_load(cfg1), .clear(clr1), .inc_addr(inc1), .cap_addr(addr1), .match_vec(vec1),
        .mem_full(full1), .pkt_cnt(pkt1), .match_cnt(mcnt1), .drop_cnt(drop1));

    always #5 clk = ~clk;

    // Input FIFO occupancy model, driven by the wrapping instance's requests.
    assign rdempty = (fcnt == 0);
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) fcnt <= 0;
        else        fcnt <= fcnt + (wr1 ? 1 : 0) - ((rd1 && fcnt > 0) ? 1 : 0);
    end

    typedef logic [AW+NCH-1:0] cap_t;
    cap_t exp0[$], exp1[$];
    cap_t obs0[32], obs1[32];
    int   nobs0 = 0, nobs1 = 0, r0 = 0, r1 = 0;

    always @(negedge clk) begin
        if (inc0 && nobs0 < 32) begin obs0[nobs0] <= {addr0, vec0}; nobs0 <= nobs0 + 1; end
        if (inc1 && nobs1 < 32) begin obs1[nobs1] <= {addr1, vec1}; nobs1 <= nobs1 + 1; end
    end

    int n_checks = 0, n_pass = 0;
    int m_pkt = 0, m_match0 = 0, m_match1 = 0, m_drop0 = 0, m_drop1 = 0, m_addr0 = 0, m_addr1 = 0;
    bit m_full0 = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check(tag, {wr0, rd0, cfg0, clr0, inc0, full0, addr0, vec0, pkt0, mcnt0, drop0}, 64'd0);
        check(tag, {wr1, rd1, cfg1, clr1, inc1, full1, addr1, vec1, pkt1, mcnt1, drop1}, 64'd0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stats0"}, {pkt0, mcnt0, drop0}, {CW'(m_pkt), CW'(m_match0), CW'(m_drop0)});
        check({tag, "_stats1"}, {pkt1, mcnt1, drop1}, {CW'(m_pkt), CW'(m_match1), CW'(m_drop1)});
        check({tag, "_addr"}, {addr0, addr1}, {AW'(m_addr0), AW'(m_addr1)});
        check({tag, "_full"}, {full0, full1}, {m_full0, 1'b0});
    endtask

    task automatic compare_caps(input string tag);
        while (exp0.size() > 0) begin
            cap_t e = exp0.pop_front();
            if (r0 < nobs0) begin check({tag, "_cap0"}, obs0[r0], e); r0++; end
            else check({tag, "_cap0_missing"}, nobs0, r0 + 1);
        end
        while (exp1.size() > 0) begin
            cap_t e = exp1.pop_front();
            if (r1 < nobs1) begin check({tag, "_cap1"}, obs1[r1], e); r1++; end
            else check({tag, "_cap1_missing"}, nobs1, r1 + 1);
        end
        check({tag, "_extra0"}, nobs0, r0);
        check({tag, "_extra1"}, nobs1, r1);
    endtask

    task automatic do_config();
        check("rst_hold_cfg", {cfg0, cfg1}, 2'b00);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("cfg_load_c%0d", c), {cfg0, cfg1}, (c <= 5) ? 2'b11 : 2'b00);
            check($sformatf("clear_c%0d", c), {clr0, clr1}, (c == 6) ? 2'b11 : 2'b00);
            if (c == 5) update_done = 1'b1;
        end
        update_done = 1'b0;
    endtask

    task automatic frame(input string tag, input int nwords, input logic [NCH-1:0] m,
                         input logic [NCH-1:0] en);
        logic hit;
        int k, lat, pulses;
        hit = |(m & en);
        check({tag, "_idle"}, {clr0, clr1}, 2'b11);
        match = m; ch_en = en; ready = 1'b1;
        tick();
        ready = 1'b0;
        check({tag, "_wrreq"}, {wr0, wr1}, 2'b11);
        for (int i = 0; i < nwords; i++) begin
            if (i == nwords - 1) eop = 1'b1;
            tick();
        end
        eop = 1'b0;
        check({tag, "_eop_to_rdreq"}, {rd0, rd1}, 2'b11);
        m_pkt++;
        if (hit) begin
            m_addr1 = (m_addr1 + 1) % (1 << AW);
            m_match1++;
            exp1.push_back({AW'(m_addr1), m & en});
            if (m_full0) m_drop0++;
            else begin
                m_addr0++;
                m_match0++;
                exp0.push_back({AW'(m_addr0), m & en});
                if (m_addr0 == (1 << AW) - 1) m_full0 = 1'b1;
            end
        end
        k = 0;
        while (!(rd1 && rdempty) && k < 40) begin tick(); k++; end
        check({tag, "_drain_timeout"}, k < 40, 1'b1);
        lat = 0; pulses = 0;
        for (int c = 1; c <= LAT + 6; c++) begin
            tick();
            if (inc1) begin pulses++; if (lat == 0) lat = c; end
            if (lat != 0 && c == lat + 1) check({tag, "_clear_after_store"}, clr1, 1'b1);
        end
        check({tag, "_latency"}, lat, hit ? LAT + 2 : 0);
        check({tag, "_pulses"}, pulses, hit ? 1 : 0);
        check({tag, "_back_idle"}, {clr0, clr1}, 2'b11);
        check_stats(tag);
        compare_caps(tag);
    endtask

    initial begin
        int k, n;
        tick();
        check_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;
        do_config();

        frame("match", 10, 4'b0100, 4'b1111);
        frame("masked", 6, 4'b0010, 4'b1101);

        // Error at the third word, eop five cycles later, three words left to flush.
        ready = 1'b1; tick(); ready = 1'b0;
        tick(); tick();
        error = 1'b1; tick(); error = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("err_hold", {wr0, wr1, rd0, rd1, clr0, clr1}, 6'd0);
            tick();
        end
        eop = 1'b1; tick(); eop = 1'b0;
        k = 0; n = 0;
        while (!clr1 && k < 30) begin if (rd1 && !rdempty) n++; tick(); k++; end
        check("err_flush_reads", n, 3);
        check("err_idle", {clr0, clr1}, 2'b11);
        check_stats("err");
        compare_caps("err");

        // Error and eop together go straight to FLUSH.
        ready = 1'b1; tick(); ready = 1'b0;
        tick();
        error = 1'b1; eop = 1'b1; tick(); error = 1'b0; eop = 1'b0;
        check("erreop_flush", {rd0, rd1}, 2'b11);
        k = 0; n = 0;
        while (!clr1 && k < 30) begin if (rd1 && !rdempty) n++; tick(); k++; end
        check("erreop_reads", n, 2);
        check_stats("erreop");
        compare_caps("erreop");

        // Oversize frame: no eop.
        ready = 1'b1; tick(); ready = 1'b0;
        n = 0;
        while (wr1 && n < 40) begin n++; tick(); end
        check("oversize_words", n, MAXW);
        m_drop0++; m_drop1++;
        check_stats("oversize");
        eop = 1'b1; tick(); eop = 1'b0;
        k = 0;
        while (!clr1 && k < 60) begin tick(); k++; end
        check("oversize_flush_done", {clr0, clr1}, 2'b11);
        compare_caps("oversize");

        // Reset in the middle of a frame.
        ready = 1'b1; tick(); ready = 1'b0;
        tick(); tick();
        #2 n_rst = 1'b0;
        #1 check_zero("midframe_reset");
        m_pkt = 0; m_match0 = 0; m_match1 = 0; m_drop0 = 0; m_drop1 = 0;
        m_addr0 = 0; m_addr1 = 0; m_full0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        do_config();

        // Address boundary with five matching frames.
        frame("b1", 10, 4'b0100, 4'b1111);
        frame("b2", 4, 4'b1010, 4'b1000);
        frame("b3", 1, 4'b1111, 4'b0011);
        frame("b4", 7, 4'b0001, 4'b0001);
        frame("b5", 2, 4'b1001, 4'b1111);
        check("boundary_drop0", drop0, CW'(2));
        check("boundary_addr1", addr1, AW'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
